// File: rtl/dsp_host_pkg.sv
// Shared types and constants for the dsp host register-bus initiator.
// Holds the FSM state encoding, the dsp address width and the address
// that maps to the local param register when that feature is built in.
package dsp_host_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WRITE     = 3'd1,
        READ_WAIT = 3'd2,
        READ_DONE = 3'd3,
        START     = 3'd4
    } state_t;

    localparam int ADDR_W = 3;

    localparam logic [ADDR_W-1:0] PARAM_ADDR = 3'b111;

endpackage

// File: rtl/dsp_host_if_if.sv
// Command/response channel between the processor bridge and dsp_host_if.
// master = bridge side (issues commands, receives read data),
// slave  = dsp_host_if side (accepts commands, returns read data).
interface dsp_host_if_if #(
    parameter int bus_width = 24
);

    logic                              cmd_valid;
    logic                              cmd_ready;
    logic                              cmd_write;
    logic [dsp_host_pkg::ADDR_W-1:0]   cmd_addr;
    logic [bus_width-1:0]              cmd_data;
    logic                              rsp_valid;
    logic [bus_width-1:0]              rsp_data;

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_data,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_data,
        output cmd_ready, rsp_valid, rsp_data
    );

endinterface

// File: rtl/dsp_host_lat_cnt.sv
// Loadable down-counter with a zero flag, used to time dsp read latency.
// Load has priority over decrement; decrement stops at zero.
// Zero flag is combinational from the count register.
module dsp_host_lat_cnt #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    // count register: load a new latency or step toward zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/dsp_host_if.sv
// Register-bus initiator for one dsp: turns valid/ready commands into a
// one-cycle write strobe or an rd_lat-cycle read, plus start pulses.
// Optional macro DSP_HOST_PARAM_EN adds a local param register at address 7.
module dsp_host_if
    import dsp_host_pkg::*;
#(
    parameter int   bus_width = 24,
    parameter int   rd_lat    = 2,
    parameter logic en_idle   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    dsp_host_if_if.slave          host,
    input  logic                  start_req,
    output logic                  busy,
    output logic                  en,
    output logic                  start,
    output logic [ADDR_W-1:0]     addr,
    output logic [bus_width-1:0]  din,
    output logic                  we,
    input  logic [bus_width-1:0]  dout
`ifdef DSP_HOST_PARAM_EN
    ,
    output logic [7:0]            param
`endif
);

    localparam int               CNT_W    = $clog2(rd_lat + 1);
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(rd_lat - 1);

    state_t state;
    state_t state_nxt;
    logic   pending_start;
    logic   accept;
    logic   cnt_zero;
    logic   wr_param;
    logic   rd_param;
    logic   cmd_ready_nxt;
    logic   busy_nxt;
    logic   en_nxt;
    logic   we_nxt;
    logic   start_nxt;
    logic   rsp_valid_nxt;
    logic [bus_width-1:0] rd_sample;

    assign accept = host.cmd_valid & host.cmd_ready;

`ifdef DSP_HOST_PARAM_EN
    // address 7 is served locally instead of going to the dsp
    assign wr_param  = (host.cmd_addr == PARAM_ADDR);
    assign rd_param  = (addr == PARAM_ADDR);
    assign rd_sample = rd_param ? bus_width'(param) : dout;
`else
    assign wr_param  = 1'b0;
    assign rd_param  = 1'b0;
    assign rd_sample = dout;
`endif

    dsp_host_lat_cnt #(
        .W (CNT_W)
    ) u_lat_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (accept & ~host.cmd_write),
        .load_val (LAT_LOAD),
        .dec      (state == READ_WAIT),
        .zero     (cnt_zero)
    );

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state: a command beats a start request; requests wait in pending_start
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = host.cmd_write ? WRITE : READ_WAIT;
                end else if (start_req || pending_start) begin
                    state_nxt = START;
                end
            end
            WRITE:     state_nxt = IDLE;
            READ_WAIT: state_nxt = cnt_zero ? READ_DONE : READ_WAIT;
            READ_DONE: state_nxt = IDLE;
            START:     state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // output decode from the upcoming state so every output can be registered
    always_comb begin
        cmd_ready_nxt = (state_nxt == IDLE);
        busy_nxt      = (state_nxt != IDLE);
        en_nxt        = ((state_nxt == WRITE) || (state_nxt == READ_WAIT)) ? 1'b1 : en_idle;
        we_nxt        = (state_nxt == WRITE) && !wr_param;
        start_nxt     = (state_nxt == START);
        rsp_valid_nxt = (state_nxt == READ_DONE);
    end

    // registered outputs; addr/din hold their last values between commands
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            host.cmd_ready <= 1'b0;
            host.rsp_valid <= 1'b0;
            host.rsp_data  <= '0;
            busy           <= 1'b0;
            en             <= 1'b0;
            start          <= 1'b0;
            addr           <= '0;
            din            <= '0;
            we             <= 1'b0;
        end else begin
            host.cmd_ready <= cmd_ready_nxt;
            host.rsp_valid <= rsp_valid_nxt;
            busy           <= busy_nxt;
            en             <= en_nxt;
            start          <= start_nxt;
            we             <= we_nxt;
            if (accept) begin
                addr <= host.cmd_addr;
                if (host.cmd_write) begin
                    din <= host.cmd_data;
                end
            end
            if ((state == READ_WAIT) && cnt_zero) begin
                host.rsp_data <= rd_sample;
            end
        end
    end

    // start requests seen while occupied collapse into one pending pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_start <= 1'b0;
        end else if (state_nxt == START) begin
            pending_start <= 1'b0;
        end else if (start_req) begin
            pending_start <= 1'b1;
        end
    end

`ifdef DSP_HOST_PARAM_EN
    // param register loads at the end of a write cycle aimed at address 7
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            param <= 8'h00;
        end else if ((state == WRITE) && rd_param) begin
            param <= din[7:0];
        end
    end
`endif

endmodule
